// File: rtl/bin_to_bcd7_seq_pkg.sv
// rtl/bin_to_bcd7_seq_pkg.sv - shared constants, state type and digit-blanking helper for the BCD converter
package bin_to_bcd7_seq_pkg;

    localparam logic [3:0]  DASH_CODE   = 4'hA;
    localparam int          NUM_DIGITS  = 7;
    localparam int          CODE_W      = 4 * NUM_DIGITS;
    localparam logic [23:0] MAX_DISPLAY = 24'd9_999_999;
    localparam logic [CODE_W-1:0] ALL_DASH = {NUM_DIGITS{DASH_CODE}};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_FIX   = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        FIX   = ST_FIX
    } state_t;

    // Replace leading zero digits above the units digit with dashes.
    // An all-zero value is shown as plain zeros so the display never goes blank-looking.
    function automatic logic [CODE_W-1:0] lz_blank(input logic [CODE_W-1:0] bcd);
        logic [CODE_W-1:0] r;
        logic              lead;
        r    = bcd;
        lead = 1'b1;
        if (bcd != '0) begin
            for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
                if (lead && (bcd[4*d +: 4] == 4'd0)) begin
                    r[4*d +: 4] = DASH_CODE;
                end else begin
                    lead = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin_to_bcd7_seq_bcd_add3.sv
// rtl/bin_to_bcd7_seq_bcd_add3.sv - single-digit double-dabble correction (+3 when digit >= 5)
module bcd_add3 (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    // Pre-correct a digit so the following left shift carries correctly into the next digit.
    always_comb begin
        nib_o = nib_i;
        if (nib_i >= 4'd5) begin
            nib_o = nib_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd7_seq.sv
// rtl/bin_to_bcd7_seq.sv - sequential shift-and-add-3 binary to 7-digit BCD converter for the segment display
module bin_to_bcd7_seq
    import bin_to_bcd7_seq_pkg::*;
#(
    parameter int BIN_W       = 24,
    parameter bit LZ_SUPPRESS = 1'b0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [BIN_W-1:0]  bin_in,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [CODE_W-1:0] code
);

    localparam int             CNT_W    = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_W - 1);

    state_t              state_q;
    logic [BIN_W-1:0]    bin_q,  bin_d;
    logic [CODE_W-1:0]   acc_q,  acc_d;
    logic [CODE_W-1:0]   acc_adj;
    logic [CNT_W-1:0]    cnt_q;
    logic                ovf_nxt_q, ovf_nxt_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                busy_q, done_q, ovf_q;

    // One correction unit per digit of the accumulator.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nib_i (acc_q[4*g +: 4]),
            .nib_o (acc_adj[4*g +: 4])
        );
    end

    // Next shift step, overflow test on the incoming value and the final display word.
    always_comb begin
        acc_d     = (acc_adj << 1) | CODE_W'(bin_q[BIN_W-1]);
        bin_d     = bin_q << 1;
        ovf_nxt_d = (64'(bin_in) > 64'(MAX_DISPLAY));
        code_d    = acc_q;
        if (ovf_nxt_q) begin
            code_d = ALL_DASH;
        end else if (LZ_SUPPRESS) begin
            code_d = lz_blank(acc_q);
        end
    end

    // Conversion FSM: capture on start, BIN_W shift steps, then publish the result.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_nxt_q <= 1'b0;
            code_q    <= ALL_DASH;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bin_q     <= bin_in;
                        acc_q     <= '0;
                        cnt_q     <= CNT_INIT;
                        ovf_nxt_q <= ovf_nxt_d;
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q <= acc_d;
                    bin_q <= bin_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    code_q  <= code_d;
                    ovf_q   <= ovf_nxt_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;
    assign code = code_q;

endmodule

// File: tb/tb_bin_to_bcd7_seq.sv
// tb/tb_bin_to_bcd7_seq.sv - scoreboard bench for the binary to BCD converter, plain and zero-blanking builds
module tb_bin_to_bcd7_seq;

    typedef struct packed {
        logic [27:0] code;
        logic        ovf;
    } exp_t;

    logic        CLK;
    logic        RST;
    logic        start;
    logic [23:0] bin_in;

    logic        busy0, done0, ovf0;
    logic [27:0] code0;
    logic        busy1, done1, ovf1;
    logic [27:0] code1;

    exp_t q0[$];
    exp_t q1[$];

    int checks;
    int errs;
    int done_seen;

    bin_to_bcd7_seq #(.BIN_W(24), .LZ_SUPPRESS(1'b0)) u_dut (
        .CLK    (CLK),
        .RST    (RST),
        .start  (start),
        .bin_in (bin_in),
        .busy   (busy0),
        .done   (done0),
        .ovf    (ovf0),
        .code   (code0)
    );

    bin_to_bcd7_seq #(.BIN_W(24), .LZ_SUPPRESS(1'b1)) u_dut_lz (
        .CLK    (CLK),
        .RST    (RST),
        .start  (start),
        .bin_in (bin_in),
        .busy   (busy1),
        .done   (done1),
        .ovf    (ovf1),
        .code   (code1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor for the plain build.
    always @(negedge CLK) begin
        if (done0 === 1'b1) begin
            done_seen++;
            if (q0.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL dut0_unexpected_done: got code %h, expected no done", code0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("dut0_code", 32'(code0), 32'(e.code));
                check("dut0_ovf",  32'(ovf0),  32'(e.ovf));
                check("dut0_busy_at_done", 32'(busy0), 32'd0);
            end
        end
    end

    // Monitor for the zero-blanking build.
    always @(negedge CLK) begin
        if (done1 === 1'b1) begin
            done_seen++;
            if (q1.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL dut1_unexpected_done: got code %h, expected no done", code1);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("dut1_code", 32'(code1), 32'(e.code));
                check("dut1_ovf",  32'(ovf1),  32'(e.ovf));
            end
        end
    end

    // Issue one conversion; optionally poke a second start during busy to verify it is ignored.
    task automatic convert(input logic [23:0] v, input logic [27:0] e0, input logic [27:0] e1,
                           input logic eo, input int inject_at);
        int cyc;
        @(posedge CLK); #1;
        bin_in = v;
        start  = 1'b1;
        q0.push_back('{code: e0, ovf: eo});
        q1.push_back('{code: e1, ovf: eo});
        @(posedge CLK); #1;
        start  = 1'b0;
        bin_in = 24'hFFFFFF;
        check("busy_after_start", 32'(busy0), 32'd1);
        cyc = 1;
        while (done0 !== 1'b1 && cyc < 100) begin
            if (inject_at != 0 && cyc == inject_at) begin
                start  = 1'b1;
                bin_in = 24'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge CLK); #1;
            cyc++;
        end
        start = 1'b0;
        check("latency", 32'(cyc), 32'd26);
    endtask

    initial begin
        checks    = 0;
        errs      = 0;
        done_seen = 0;
        RST       = 1'b1;
        start     = 1'b0;
        bin_in    = 24'd0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_code0", 32'(code0), 32'h0AAAAAAA);
        check("rst_code1", 32'(code1), 32'h0AAAAAAA);
        check("rst_busy",  32'(busy0), 32'd0);
        check("rst_done",  32'(done0), 32'd0);
        check("rst_ovf",   32'(ovf0),  32'd0);

        convert(24'd1_234_567, 28'h1234567, 28'h1234567, 1'b0, 0);
        convert(24'd9_999_999, 28'h9999999, 28'h9999999, 1'b0, 0);
        convert(24'd10_000_000, 28'hAAAAAAA, 28'hAAAAAAA, 1'b1, 0);
        convert(24'd42,        28'h0000042, 28'hAAAAA42, 1'b0, 0);
        convert(24'd0,         28'h0000000, 28'h0000000, 1'b0, 0);
        convert(24'd8_000_900, 28'h8000900, 28'h8000900, 1'b0, 0);
        convert(24'd5,         28'h0000005, 28'hAAAAAA5, 1'b0, 0);
        convert(24'hFFFFFF,    28'hAAAAAAA, 28'hAAAAAAA, 1'b1, 0);
        convert(24'd305,       28'h0000305, 28'hAAAA305, 1'b0, 5);

        // The poked start must not have launched a second conversion.
        repeat (30) @(posedge CLK);
        #1;
        check("ignored_start_busy", 32'(busy0), 32'd0);
        check("ignored_start_code", 32'(code0), 32'h0000305);

        // Leave ovf set, then abort a conversion with reset ten cycles in.
        convert(24'd12_000_000, 28'hAAAAAAA, 28'hAAAAAAA, 1'b1, 0);
        @(posedge CLK); #1;
        bin_in = 24'd123;
        start  = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (9) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        check("abort_code0", 32'(code0), 32'h0AAAAAAA);
        check("abort_code1", 32'(code1), 32'h0AAAAAAA);
        check("abort_busy",  32'(busy0), 32'd0);
        check("abort_done",  32'(done0), 32'd0);
        check("abort_ovf",   32'(ovf0),  32'd0);

        // Start asserted together with reset is dropped.
        start  = 1'b1;
        bin_in = 24'd77;
        @(posedge CLK); #1;
        RST   = 1'b0;
        start = 1'b0;
        @(posedge CLK); #1;
        check("rst_start_busy", 32'(busy0), 32'd0);

        done_seen = 0;
        repeat (40) @(posedge CLK);
        #1;
        check("no_done_after_abort", 32'(done_seen), 32'd0);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion, expected finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
